// File: rtl/bwn_if_pkg.sv
// Shared types and constants for the BWN UART load path.
// Optional checksum stage: define LOAD_CHKSUM_EN.
package bwn_if_pkg;

  localparam int ADDR_W = 12;

  localparam logic [7:0] ACK_OK  = 8'hA5;
  localparam logic [7:0] ACK_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
`ifdef LOAD_CHKSUM_EN
    ST_CHK  = 3'd2,
`endif
    ST_ACK  = 3'd3,
    ST_ACKW = 3'd4,
    ST_READ = 3'd5
  } state_t;

endpackage

// File: rtl/uart_load_ctrl_if.sv
// UART / buffer-RAM signal bundle of the load controller.
// master = environment side, slave = controller side.
interface uart_load_ctrl_if #(
  parameter int D_WL = 24
);

  logic                          w_x_en;
  logic [7:0]                    rx_data;
  logic                          rx_finish;
  logic                          tx_finish;
  logic                          rd_start;
  logic [bwn_if_pkg::ADDR_W-1:0] ram_w_addr;
  logic [D_WL-1:0]               ram_w_data;
  logic                          ram_w_en;
  logic [bwn_if_pkg::ADDR_W-1:0] ram_r_addr;
  logic                          ram_r_en;
  logic [7:0]                    tx_data;
  logic                          tx_en;
  logic                          d_o_valid;
  logic                          load_done;
  logic                          busy;
  logic                          chk_err;

  modport master (
    output w_x_en, rx_data, rx_finish,
    output tx_finish, rd_start,
    input  ram_w_addr, ram_w_data, ram_w_en,
    input  ram_r_addr, ram_r_en,
    input  tx_data, tx_en, d_o_valid,
    input  load_done, busy, chk_err
  );

  modport slave (
    input  w_x_en, rx_data, rx_finish,
    input  tx_finish, rd_start,
    output ram_w_addr, ram_w_data, ram_w_en,
    output ram_r_addr, ram_r_en,
    output tx_data, tx_en, d_o_valid,
    output load_done, busy, chk_err
  );

endinterface

// File: rtl/uart_load_ctrl_byte_packer.sv
// MSB-first byte-to-word packer; pulses o_word_vld
// the cycle after the last byte of each word.
module byte_packer #(
  parameter int D_WL = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_byte_vld,
  input  logic [7:0]      i_byte,
  output logic [D_WL-1:0] o_word,
  output logic            o_word_vld
);

  localparam int BYTES = (D_WL + 7) / 8;
  localparam int SW    = BYTES * 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [SW-1:0] r_sh;
  logic [CW-1:0] r_cnt;
  logic          r_vld;

  // shift bytes in, count them, flag each completed word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (i_clr) begin
        r_sh  <= '0;
        r_cnt <= '0;
      end else if (i_byte_vld) begin
        r_sh <= (r_sh << 8) | SW'(i_byte);
        if (r_cnt == CW'(BYTES - 1)) begin
          r_cnt <= '0;
          r_vld <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_word     = r_sh[D_WL-1:0];
  assign o_word_vld = r_vld;

endmodule

// File: rtl/uart_load_ctrl.sv
// UART-fed load / readout sequencer for the BWN input buffer.
// Optional checksum stage: define LOAD_CHKSUM_EN.
module uart_load_ctrl
  import bwn_if_pkg::*;
#(
  parameter int CLK_Period = 20000000,
  parameter int D_WL       = 24,
  parameter int INPUT_SIZE = 20
) (
  input logic             clk,
  input logic             rst,
  uart_load_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(INPUT_SIZE - 1);

  if (INPUT_SIZE < 1 || INPUT_SIZE > 4096 ||
      CLK_Period < 1) begin : g_cfg_bad
    $error("uart_load_ctrl: bad parameters");
  end

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wc;
  logic [ADDR_W-1:0] r_ra;
  logic              r_load_done;
  logic              r_dv;
  logic [7:0]        r_tx_data;
  logic              r_chk_err;

  logic              w_abort;
  logic              w_wr;
  logic              w_last_wr;
  logic              w_start;
  logic              w_acc;
  logic              w_word_vld;
  logic [D_WL-1:0]   w_word;
  logic              w_ram_w_en;
  logic              w_ram_r_en;
  logic              w_tx_en;
  logic              w_busy;

  assign w_abort   = (r_state == ST_LOAD) &&
                     !bus.w_x_en;
  assign w_wr      = (r_state == ST_LOAD) &&
                     bus.w_x_en && w_word_vld;
  assign w_last_wr = w_wr && (r_wc == LAST);
  assign w_start   = (r_state == ST_IDLE) &&
                     bus.rx_finish && bus.w_x_en;
  assign w_acc     = w_start ||
                     ((r_state == ST_LOAD) &&
                      bus.rx_finish && bus.w_x_en &&
                      !w_last_wr);

  byte_packer #(
    .D_WL (D_WL)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_abort),
    .i_byte_vld (w_acc),
    .i_byte     (bus.rx_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next-state: load wins over readout in IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start)
          w_next = ST_LOAD;
        else if (bus.rd_start && r_load_done)
          w_next = ST_READ;
      end
      ST_LOAD: begin
        if (w_abort)
          w_next = ST_IDLE;
        else if (w_last_wr)
`ifdef LOAD_CHKSUM_EN
          w_next = ST_CHK;
`else
          w_next = ST_ACK;
`endif
      end
`ifdef LOAD_CHKSUM_EN
      ST_CHK: begin
        if (bus.rx_finish) w_next = ST_ACK;
      end
`endif
      ST_ACK:  w_next = ST_ACKW;
      ST_ACKW: begin
        if (bus.tx_finish) w_next = ST_IDLE;
      end
      ST_READ: begin
        if (r_ra == LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // state-decoded strobes
  always_comb begin
    w_ram_w_en = w_wr;
    w_ram_r_en = (r_state == ST_READ);
    w_tx_en    = (r_state == ST_ACK);
    w_busy     = (r_state != ST_IDLE);
  end

  // write word counter, cleared on abort or frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wc <= '0;
    else if (w_abort || w_last_wr)
      r_wc <= '0;
    else if (w_wr)
      r_wc <= r_wc + 1'b1;
  end

  // readout address walks 0..LAST once per request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ra <= '0;
    else if (r_state == ST_READ)
      r_ra <= (r_ra == LAST) ? '0 : r_ra + 1'b1;
  end

  // RAM read data arrives one cycle after the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dv <= 1'b0;
    else     r_dv <= w_ram_r_en;
  end

`ifdef LOAD_CHKSUM_EN
  logic [7:0] r_sum;

  // running modulo-256 byte sum of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sum <= '0;
    else if (w_start)
      r_sum <= bus.rx_data;
    else if (w_abort)
      r_sum <= '0;
    else if (w_acc)
      r_sum <= r_sum + bus.rx_data;
  end

  // compare checksum byte, pick ack code, latch error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= '0;
      r_chk_err <= 1'b0;
    end else if ((r_state == ST_CHK) &&
                 bus.rx_finish) begin
      if (bus.rx_data == r_sum) begin
        r_tx_data <= ACK_OK;
        r_chk_err <= 1'b0;
      end else begin
        r_tx_data <= ACK_ERR;
        r_chk_err <= 1'b1;
      end
    end
  end
`else
  // ack code is fixed once the last word lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tx_data <= '0;
    else if (w_last_wr)
      r_tx_data <= ACK_OK;
  end

  assign r_chk_err = 1'b0;
`endif

  // frame-resident flag: drops on a new load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_load_done <= 1'b0;
    else if (w_start)
      r_load_done <= 1'b0;
    else if ((r_state == ST_ACKW) &&
             bus.tx_finish)
      r_load_done <= !r_chk_err;
  end

  assign bus.ram_w_addr = r_wc;
  assign bus.ram_w_data = w_word;
  assign bus.ram_w_en   = w_ram_w_en;
  assign bus.ram_r_addr = r_ra;
  assign bus.ram_r_en   = w_ram_r_en;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_en      = w_tx_en;
  assign bus.d_o_valid  = r_dv;
  assign bus.load_done  = r_load_done;
  assign bus.busy       = w_busy;
  assign bus.chk_err    = r_chk_err;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Self-checking bench for uart_load_ctrl.
// Honours LOAD_CHKSUM_EN when defined.
module tb_uart_load_ctrl;
  import bwn_if_pkg::*;

  localparam int D_WL       = 24;
  localparam int INPUT_SIZE = 20;
  localparam int BYTES      = (D_WL + 7) / 8;
  localparam int NB         = INPUT_SIZE * BYTES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_load_ctrl_if #(.D_WL(D_WL)) bus();

  uart_load_ctrl #(
    .CLK_Period (20000000),
    .D_WL       (D_WL),
    .INPUT_SIZE (INPUT_SIZE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int nbytes;
    bit seq;
    bit rd_mid;
    int exp_wr;
    int exp_ack;
    bit exp_done;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [D_WL-1:0]   wd_q[$];
  logic [7:0]        fb[$];
  int                n_tx, n_ren, n_dv, rd_bad;
  int                dv_first, dv_last;
  logic [7:0]        last_tx;
  logic [ADDR_W-1:0] rd_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ram_w_en) begin
      wa_q.push_back(bus.ram_w_addr);
      wd_q.push_back(bus.ram_w_data);
    end
    if (bus.tx_en) begin
      n_tx++;
      last_tx = bus.tx_data;
    end
    if (bus.ram_r_en) begin
      if (bus.ram_r_addr != rd_exp) rd_bad++;
      rd_exp = rd_exp + 1'b1;
      n_ren++;
    end
    if (bus.d_o_valid) begin
      if (n_dv == 0) dv_first = cyc;
      dv_last = cyc;
      n_dv++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [D_WL-1:0] model_word(int w);
    logic [BYTES*8-1:0] acc;
    acc = '0;
    for (int k = 0; k < BYTES; k++)
      acc = (acc << 8) | (BYTES*8)'(fb[w*BYTES+k]);
    return acc[D_WL-1:0];
  endfunction

  function automatic logic [7:0] model_sum();
    int s;
    s = 0;
    foreach (fb[i]) s += int'(fb[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data   = b;
    bus.rx_finish = 1'b1;
    @(posedge clk); #1;
    bus.rx_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    bus.rd_start = 1'b1;
    @(posedge clk); #1;
    bus.rd_start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wen"},   32'(bus.ram_w_en),   0);
    chk({tag, "_waddr"}, 32'(bus.ram_w_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.ram_w_data), 0);
    chk({tag, "_ren"},   32'(bus.ram_r_en),   0);
    chk({tag, "_raddr"}, 32'(bus.ram_r_addr), 0);
    chk({tag, "_txen"},  32'(bus.tx_en),      0);
    chk({tag, "_txd"},   32'(bus.tx_data),    0);
    chk({tag, "_dov"},   32'(bus.d_o_valid),  0);
    chk({tag, "_done"},  32'(bus.load_done),  0);
    chk({tag, "_busy"},  32'(bus.busy),       0);
    chk({tag, "_cerr"},  32'(bus.chk_err),    0);
  endtask

  task automatic run_frame(input vec_t v,
                           input bit sum_ok);
    logic [7:0] ack;
    fb.delete();
    for (int i = 0; i < v.nbytes; i++)
      fb.push_back(v.seq ? 8'(i) : 8'($urandom));
    wa_q.delete();
    wd_q.delete();
    n_tx  = 0;
    n_ren = 0;
    bus.w_x_en = 1'b1;
    for (int i = 0; i < v.nbytes; i++) begin
      send_byte(fb[i]);
      if (v.rd_mid && i == 10) pulse_rd();
    end
    if (v.nbytes < NB) begin
      bus.w_x_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle", 32'(bus.busy), 0);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_done", 32'(bus.load_done), 0);
    end else begin
`ifdef LOAD_CHKSUM_EN
      send_byte(sum_ok ? model_sum()
                       : model_sum() + 8'd1);
      ack = sum_ok ? ACK_OK : ACK_ERR;
`else
      ack = ACK_OK;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("ack_byte", 32'(last_tx), 32'(ack));
      chk("ackw_busy", 32'(bus.busy), 1);
      chk("done_pre", 32'(bus.load_done), 0);
      bus.tx_finish = 1'b1;
      @(posedge clk); #1;
      bus.tx_finish = 1'b0;
      chk("done_post", 32'(bus.load_done),
          32'(v.exp_done && sum_ok));
      chk("idle_post", 32'(bus.busy), 0);
`ifdef LOAD_CHKSUM_EN
      chk("chk_err", 32'(bus.chk_err), 32'(!sum_ok));
`endif
    end
    chk("n_ack", n_tx, v.exp_ack);
    chk("n_wr", wa_q.size(), v.exp_wr);
    chk("n_wr_model", wa_q.size(), v.nbytes / BYTES);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk($sformatf("waddr%0d", i), 32'(wa_q[i]), i);
      chk($sformatf("wdata%0d", i), 32'(wd_q[i]),
          32'(model_word(i)));
    end
    chk("rd_in_load", n_ren, 0);
  endtask

  task automatic do_read(input bit ok, input bit inj);
    int t0;
    n_ren  = 0;
    n_dv   = 0;
    rd_bad = 0;
    rd_exp = '0;
    dv_first = -1;
    dv_last  = -1;
    wa_q.delete();
    t0 = cyc;
    pulse_rd();
    if (inj) begin
      bus.w_x_en = 1'b1;
      for (int k = 0; k < 3; k++)
        send_byte(8'($urandom));
    end
    repeat (INPUT_SIZE + 4) @(posedge clk);
    #1;
    chk("n_ren", n_ren, ok ? INPUT_SIZE : 0);
    chk("n_dv", n_dv, ok ? INPUT_SIZE : 0);
    chk("raddr_seq", rd_bad, 0);
    if (ok) begin
      chk("dv_first", dv_first, t0 + 2);
      chk("dv_last", dv_last, t0 + INPUT_SIZE + 1);
    end
    chk("rd_idle", 32'(bus.busy), 0);
    chk("rd_nowr", wa_q.size(), 0);
    chk("rd_done", 32'(bus.load_done), 32'(ok));
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{60, 1'b1, 1'b0, 20, 1, 1'b1};
    vt[1] = '{32, 1'b0, 1'b0, 10, 0, 1'b0};
    vt[2] = '{60, 1'b0, 1'b1, 20, 1, 1'b1};
    vt[3] = '{ 5, 1'b0, 1'b0,  1, 0, 1'b0};
    vt[4] = '{60, 1'b0, 1'b0, 20, 1, 1'b1};

    bus.w_x_en    = 1'b0;
    bus.rx_data   = '0;
    bus.rx_finish = 1'b0;
    bus.tx_finish = 1'b0;
    bus.rd_start  = 1'b0;
    n_tx = 0; n_ren = 0; n_dv = 0; rd_bad = 0;
    rd_exp = '0; last_tx = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    send_byte(8'h55);
    chk("drop_busy", 32'(bus.busy), 0);
    chk("drop_nowr", wa_q.size(), 0);

    do_read(1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i], 1'b1);
      if (i == 0 && wd_q.size() == 20) begin
        chk("w0_const", 32'(wd_q[0]), 32'h000102);
        chk("w19_const", 32'(wd_q[19]), 32'h393A3B);
      end
      do_read(vt[i].exp_done, vt[i].exp_done);
    end

    fb.delete();
    wa_q.delete();
    wd_q.delete();
    bus.w_x_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      fb.push_back(8'($urandom));
      send_byte(fb[i]);
    end
    chk("pre_rst_wr", wa_q.size(), 7);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(vt[4], 1'b1);
    do_read(1'b1, 1'b0);

`ifdef LOAD_CHKSUM_EN
    run_frame(vt[4], 1'b0);
    do_read(1'b0, 1'b0);
    run_frame(vt[4], 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
